// File: rtl/shift_pin_nib_out_if.sv
// Bundle for the TI->Pi nibble link: TI load port, Pi strobe/select and status.
// master drives the TI/Pi side, slave is the shift register.
interface shift_pin_nib_out_if #(
  parameter int unsigned WIDTH = 8
) ();
  localparam int unsigned NIBS  = WIDTH / 4;
  localparam int unsigned CNT_W = $clog2(NIBS + 1);

  logic               le;
  logic [0:WIDTH-1]   din;
  logic               select;
  logic               pi_clk;
  wire  [0:3]         dout;
  logic               empty;
  logic [CNT_W-1:0]   nib_cnt;
  logic               overrun;

  modport master (
    output le, din, select, pi_clk,
    input  dout, empty, nib_cnt, overrun
  );

  modport slave (
    input  le, din, select, pi_clk,
    output dout, empty, nib_cnt, overrun
  );
endinterface

// File: rtl/shift_pin_nib_out.sv
// Parallel-in, nibble-serial-out shift register (TI->Pi), MS nibble first.
// Define SYNC_EN to pass pi_clk through a 2-flop synchroniser and rising-edge detector.
module shift_pin_nib_out #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_pin_nib_out_if.slave   bus
);
  localparam int unsigned NIBS  = WIDTH / 4;
  localparam int unsigned CNT_W = $clog2(NIBS + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(NIBS);

  typedef enum logic [1:0] {StIdle, StLoaded, StShifting, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [0:WIDTH-1]   r_shift, w_shift_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic               r_overrun, w_overrun_d;
  logic               w_sh;

`ifdef SYNC_EN
  logic r_sync1, r_sync2, r_edge;

  // Edge register keeps tracking in every state so a held-high strobe shifts only once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= bus.pi_clk;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
    end
  end

  assign w_sh = r_sync2 & ~r_edge;
`else
  assign w_sh = bus.pi_clk;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_shift   <= w_shift_d;
      r_cnt     <= w_cnt_d;
      r_overrun <= w_overrun_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_shift_d   = r_shift;
    w_cnt_d     = r_cnt;
    w_overrun_d = r_overrun;
    unique case (r_state)
      // Load wins over a simultaneous strobe when no word is in flight.
      StIdle, StDone: begin
        if (bus.le) begin
          w_shift_d   = bus.din;
          w_cnt_d     = '0;
          w_state_d   = StLoaded;
          w_overrun_d = 1'b0;
        end
      end
      StLoaded, StShifting: begin
        if (bus.le) begin
          w_overrun_d = 1'b1;
        end
        if (w_sh && bus.select) begin
          w_shift_d = {r_shift[4:WIDTH-1], 4'b0000};
          w_cnt_d   = r_cnt + CNT_W'(1);
          w_state_d = (w_cnt_d == CntMax) ? StDone : StShifting;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign bus.dout    = bus.select ? r_shift[0:3] : 4'bzzzz;
  assign bus.empty   = (r_state == StIdle) || (r_state == StDone);
  assign bus.nib_cnt = r_cnt;
  assign bus.overrun = r_overrun;
endmodule
